// File: rtl/pad_rd.sv
// Read engine for a byte-wide peripheral reached through bicell pads: presents an
// address, pulses an active-low read strobe, waits for a synchronised ready, captures pad data.
module pad_rd #(
  parameter int DW       = 8,
  parameter int AW       = 16,
  parameter int WAIT_CYC = 3,
  parameter int TMO_CYC  = 31
) (
  input  logic          C,
  input  logic          RN,
  input  logic          REQ,
  input  logic [AW-1:0] ADDR,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [DW-1:0] DATA,
  output logic [AW-1:0] PA,
  output logic          PIE,
  output logic          PRD_N,
  input  logic          PRDY,
  input  logic [DW-1:0] PD
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    CAPTURE,
    DONE_ST
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_CYC - 1);
  localparam logic [7:0] TMO_LIM  = 8'(TMO_CYC - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       rdy_p0;
  logic       rdy_p1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The pad is never driven from this block while reading.
  assign PIE = 1'b0;

  // PRDY synchroniser stages p0/p1
  always_ff @(posedge C) begin
    if (!RN) begin
      rdy_p0 <= 1'b0;
      rdy_p1 <= 1'b0;
    end else begin
      rdy_p0 <= PRDY;
      rdy_p1 <= rdy_p0;
    end
  end

  always_ff @(posedge C) begin
    if (!RN) begin
      state <= IDLE;
      cnt   <= 8'd0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
      DATA  <= '0;
      PA    <= '0;
      PRD_N <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (REQ) begin
            PA    <= ADDR;
            BUSY  <= 1'b1;
            ERR   <= 1'b0;
            state <= SETUP;
          end
        end
        SETUP: begin
          cnt   <= 8'd0;
          PRD_N <= 1'b0;
          state <= STROBE;
        end
        STROBE: begin
          cnt <= sat_inc(cnt);
          // Ready wins over timeout when both hold in the same cycle.
          if (cnt >= WAIT_LIM && rdy_p1) begin
            state <= CAPTURE;
          end else if (cnt == TMO_LIM) begin
            PRD_N <= 1'b1;
            DONE  <= 1'b1;
            ERR   <= 1'b1;
            state <= DONE_ST;
          end
        end
        CAPTURE: begin
          DATA  <= PD;
          PRD_N <= 1'b1;
          DONE  <= 1'b1;
          ERR   <= 1'b0;
          state <= DONE_ST;
        end
        DONE_ST: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          PRD_N <= 1'b1;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pad_rd.sv
// Bench for pad_rd: directed reads against a cycle-level behavioural model,
// plus literal latency/strobe-width expectations for each scenario.
module tb_pad_rd;

  localparam int DW       = 8;
  localparam int AW       = 16;
  localparam int WAIT_CYC = 3;
  localparam int TMO_CYC  = 31;

  logic          C = 1'b0;
  logic          RN = 1'b0;
  logic          REQ = 1'b0;
  logic [AW-1:0] ADDR = '0;
  logic          BUSY, DONE, ERR, PIE, PRD_N;
  logic [DW-1:0] DATA;
  logic [AW-1:0] PA;
  logic          PRDY = 1'b0;
  logic [DW-1:0] PD = '0;

  pad_rd #(.DW(DW), .AW(AW), .WAIT_CYC(WAIT_CYC), .TMO_CYC(TMO_CYC)) dut (
    .C(C), .RN(RN), .REQ(REQ), .ADDR(ADDR), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .DATA(DATA), .PA(PA), .PIE(PIE), .PRD_N(PRD_N), .PRDY(PRDY), .PD(PD)
  );

  always #5 C = ~C;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model: m_t counts edges since the request was accepted
  // (-1 idle, -2 the completion cycle); strobe index k = m_t-1.
  logic          m_valid = 1'b0;
  int            m_t = -1;
  logic          m_cap = 1'b0;
  logic          m_rs0 = 1'b0, m_rs1 = 1'b0;
  logic          e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0, e_prdn = 1'b1;
  logic [DW-1:0] e_data = '0;
  logic [AW-1:0] e_pa = '0;

  always @(posedge C) begin
    if (!RN) begin
      m_valid <= 1'b1;
      m_t     <= -1;
      m_cap   <= 1'b0;
      m_rs0   <= 1'b0;
      m_rs1   <= 1'b0;
      e_busy  <= 1'b0;
      e_done  <= 1'b0;
      e_err   <= 1'b0;
      e_prdn  <= 1'b1;
      e_data  <= '0;
      e_pa    <= '0;
    end else begin
      m_rs0 <= PRDY;
      m_rs1 <= m_rs0;
      if (m_t == -1) begin
        if (REQ) begin
          m_t    <= 0;
          e_pa   <= ADDR;
          e_busy <= 1'b1;
          e_err  <= 1'b0;
        end
      end else if (m_t == -2) begin
        m_t    <= -1;
        m_cap  <= 1'b0;
        e_done <= 1'b0;
        e_busy <= 1'b0;
      end else if (m_t == 0) begin
        m_t    <= 1;
        e_prdn <= 1'b0;
      end else if (!m_cap) begin
        if ((m_t - 1) >= WAIT_CYC - 1 && m_rs1) begin
          m_cap <= 1'b1;
          m_t   <= m_t + 1;
        end else if ((m_t - 1) == TMO_CYC - 1) begin
          m_t    <= -2;
          e_done <= 1'b1;
          e_err  <= 1'b1;
          e_prdn <= 1'b1;
        end else begin
          m_t <= m_t + 1;
        end
      end else begin
        m_t    <= -2;
        e_data <= PD;
        e_done <= 1'b1;
        e_err  <= 1'b0;
        e_prdn <= 1'b1;
      end
    end
  end

  always @(negedge C) begin
    if (m_valid) begin
      check("busy", 32'(BUSY), 32'(e_busy));
      check("done", 32'(DONE), 32'(e_done));
      check("err", 32'(ERR), 32'(e_err));
      check("data", 32'(DATA), 32'(e_data));
      check("pa", 32'(PA), 32'(e_pa));
      check("prd_n", 32'(PRD_N), 32'(e_prdn));
      check("pie", 32'(PIE), 32'd0);
    end
  end

  // One read: REQ for a single edge; PRDY/PD switched on at cycle rdy_at (if > 0).
  // lat = edges from the REQ edge to DONE inclusive, low = cycles with PRD_N low.
  task automatic run_read(input logic [AW-1:0] a, input logic [DW-1:0] pd, input int rdy_at,
                          output int lat, output int low);
    @(negedge C);
    REQ = 1'b1;
    ADDR = a;
    PD = (rdy_at > 0) ? ~pd : pd;
    lat = -1;
    low = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge C);
      if (cyc == 1) REQ = 1'b0;
      if (cyc == rdy_at) begin
        PRDY = 1'b1;
        PD = pd;
      end
      if (!PRD_N) low++;
      if (DONE) begin
        lat = cyc;
        break;
      end
    end
  endtask

  int lat, low, d1, d2;

  initial begin
    repeat (3) @(negedge C);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_prdn", 32'(PRD_N), 32'd1);
    check("rst_data", 32'(DATA), 32'd0);
    RN = 1'b1;
    PRDY = 1'b1;
    repeat (3) @(negedge C);

    // Basic read with ready already synchronised
    run_read(16'h1234, 8'hA5, 0, lat, low);
    check("basic_lat", 32'(lat), 32'd6);
    check("basic_low", 32'(low), 32'd4);
    check("basic_data", 32'(DATA), 32'hA5);
    check("basic_err", 32'(ERR), 32'd0);
    check("basic_pa", 32'(PA), 32'h1234);

    // Reset in the middle of the strobe
    PRDY = 1'b0;
    repeat (3) @(negedge C);
    REQ = 1'b1;
    ADDR = 16'h5555;
    @(negedge C);
    REQ = 1'b0;
    repeat (3) @(negedge C);
    check("mid_prdn", 32'(PRD_N), 32'd0);
    RN = 1'b0;
    @(negedge C);
    check("rst2_prdn", 32'(PRD_N), 32'd1);
    check("rst2_busy", 32'(BUSY), 32'd0);
    check("rst2_data", 32'(DATA), 32'd0);
    check("rst2_pa", 32'(PA), 32'd0);
    check("rst2_done", 32'(DONE), 32'd0);
    RN = 1'b1;
    repeat (3) begin
      @(negedge C);
      check("rst2_idle", 32'({BUSY, DONE, PRD_N}), 32'b001);
    end

    // Slow peripheral: PRDY rises after seven strobe-low cycles
    run_read(16'h00C3, 8'h3C, 8, lat, low);
    check("slow_lat", 32'(lat), 32'd12);
    check("slow_low", 32'(low), 32'd10);
    check("slow_data", 32'(DATA), 32'h3C);
    check("slow_err", 32'(ERR), 32'd0);

    // Timeout: data from the previous read must survive
    PRDY = 1'b0;
    repeat (3) @(negedge C);
    run_read(16'h0BAD, 8'h77, -1, lat, low);
    check("tmo_lat", 32'(lat), 32'd33);
    check("tmo_low", 32'(low), 32'd31);
    check("tmo_err", 32'(ERR), 32'd1);
    check("tmo_data", 32'(DATA), 32'h3C);
    check("tmo_pa", 32'(PA), 32'h0BAD);

    // Synchronised ready arrives exactly on the last strobe cycle
    run_read(16'h0C0D, 8'h5A, 30, lat, low);
    check("race_lat", 32'(lat), 32'd34);
    check("race_low", 32'(low), 32'd32);
    check("race_err", 32'(ERR), 32'd0);
    check("race_data", 32'(DATA), 32'h5A);

    // Back-to-back with REQ held high; ADDR change mid-read is ignored
    repeat (3) @(negedge C);
    REQ = 1'b1;
    ADDR = 16'h0001;
    PD = 8'h11;
    d1 = -1;
    d2 = -1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge C);
      if (cyc == 3) ADDR = 16'h0002;
      if (cyc == 4) check("b2b_pa_hold", 32'(PA), 32'h0001);
      if (DONE && d1 < 0) begin
        d1 = cyc;
        check("b2b_data1", 32'(DATA), 32'h11);
        PD = 8'h22;
      end else if (d1 > 0 && cyc == d1 + 1) begin
        check("b2b_gap_busy", 32'(BUSY), 32'd0);
      end else if (d1 > 0 && cyc == d1 + 2) begin
        check("b2b_busy2", 32'(BUSY), 32'd1);
        check("b2b_pa2", 32'(PA), 32'h0002);
      end else if (DONE && d1 > 0) begin
        d2 = cyc;
        break;
      end
    end
    REQ = 1'b0;
    check("b2b_d1", 32'(d1), 32'd6);
    check("b2b_d2", 32'(d2), 32'd13);
    check("b2b_data2", 32'(DATA), 32'h22);
    repeat (3) @(negedge C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pad_rd.md
# pad_rd

Synchronous read engine for an external byte-wide peripheral bus reached through bidirectional pad cells. On a request, it presents an address and asserts an active-low read strobe. It keeps the pad output enable deasserted so the peripheral can drive the pins, waits a programmable number of wait states plus a synchronised ready, and then captures the pad input data. It is the receive-direction counterpart of the IHU's pad write path and sits between IHU core logic and the bicell pads.

## Interface
Parameters:
- DW, 8, data width (pad data lines)
- AW, 16, address width
- WAIT_CYC, 3, minimum strobe-low cycles before ready is honoured (1..15)
- TMO_CYC, 31, maximum strobe-low cycles before timeout (must be > WAIT_CYC, <= 255)

Ports:
- C  in  1  clock; single clock domain
- RN  in  1  reset, synchronous, active-low
- REQ  in  1  read request; sampled only in IDLE
- ADDR  in  AW  read address; captured with REQ
- BUSY  out  1  high from accepted request until return to IDLE
- DONE  out  1  one-cycle pulse, read complete (data valid or error)
- ERR  out  1  valid with DONE; 1 = timeout
- DATA  out  DW  captured read data; holds until the next capture
- PA  out  AW  pad address lines
- PIE  out  1  pad data output enable (bicell IE); constant 0 from this block
- PRD_N  out  1  pad read strobe, active-low
- PRDY  in  1  peripheral ready, asynchronous
- PD  in  DW  pad data input (bicell IZ), asynchronous

## Operation
- Reset (RN=0 at a rising edge of C) forces: state IDLE, BUSY=0, DONE=0, ERR=0, DATA=0, PA=0, PRD_N=1, PIE=0, wait counter=0, both PRDY synchroniser flops=0. A reset in any state aborts the cycle immediately, with no DONE pulse.
- PRDY passes through a 2-flop synchroniser (RDY_S). PD is sampled only in CAPTURE. The peripheral holds PD stable while PRDY is high.
- States:
  - IDLE: PRD_N=1. If REQ=1: latch ADDR into PA, go to SETUP, BUSY=1.
  - SETUP: one cycle of address setup with PRD_N=1. Go to STROBE, and clear the counter.
  - STROBE: PRD_N=0; the counter increments each cycle (8-bit, saturating).
    - If counter >= WAIT_CYC-1 and RDY_S=1: go to CAPTURE.
    - Else if counter = TMO_CYC-1: go to DONE_ST with ERR=1.
    - Ready takes priority over timeout in the same cycle.
  - CAPTURE: PRD_N=0; DATA <= PD; go to DONE_ST with ERR=0.
  - DONE_ST: PRD_N=1; DONE=1 for this cycle only. Go to IDLE; BUSY drops entering IDLE.
- On timeout, DATA keeps its previous value.
- PA holds its last address after the cycle; it changes only when a new request is accepted.
- REQ outside IDLE is ignored; there is no queueing.
- REQ held high continuously starts a new cycle on the cycle after returning to IDLE, with one IDLE cycle between reads.
- PIE is tied 0 inside the block so the pad never drives while reading.

## Timing
- With REQ sampled at edge 0:
  - SETUP at edge 1.
  - PRD_N falls at edge 2.
  - CAPTURE occurs at the first edge where the counter >= WAIT_CYC-1 and RDY_S=1.
  - DONE is one cycle after CAPTURE.
- Minimum latency from REQ edge to DONE high, with PRDY already high long enough to be synchronised: WAIT_CYC+3 cycles. For WAIT_CYC=3 that is 6 cycles, and PRD_N is low for WAIT_CYC+1 = 4 cycles (STROBE ×3 + CAPTURE).
- PRDY rising late adds synchroniser latency: 2 cycles from the PRDY edge to RDY_S.
- Timeout: PRD_N is low for exactly TMO_CYC cycles, followed by DONE with ERR=1. Total latency is TMO_CYC+2 cycles from REQ.
- BUSY is high from edge 1 through the DONE_ST cycle inclusive.
- DONE, ERR and DATA change on the same edge. ERR returns to 0 on the next accepted request.

## Test plan
- Reset: drive RN=0 mid-STROBE. The next edge must give PRD_N=1, BUSY=0, DATA=0, PA=0, no DONE, and the state returns to IDLE.
- Basic read: WAIT_CYC=3, PRDY held 1, REQ with ADDR=0x1234, PD=0xA5. Expect PA=0x1234 at edge 1, PRD_N low for 4 cycles, DONE at cycle 6, DATA=0xA5, ERR=0.
- Slow peripheral: PRDY rises 7 cycles after PRD_N falls, PD=0x3C. Expect capture 2 cycles after PRDY, DATA=0x3C, ERR=0.
- Timeout: TMO_CYC=31, PRDY held 0. Expect PRD_N low for 31 cycles, DONE with ERR=1, DATA unchanged from the previous read.
- Ready vs timeout: RDY_S rises exactly at counter=TMO_CYC-1. Expect the CAPTURE path with ERR=0.
- Back-to-back: REQ held 1 with ADDR=0x0001 then 0x0002. Expect two reads, one IDLE cycle between DONE and the next SETUP, and REQ ignored while BUSY=1.
